// File: rtl/ex_issue_pkg.sv
// Shared types for the EX issue stage: occupancy encodings, the held-op
// record, and the ALU function codes shared with the execute unit.
package ex_issue_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int FUNC_W = 6;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_e;

  // ALU function codes; this stage passes them through untouched.
  localparam logic [FUNC_W-1:0] FUNC_SLL = 6'b000000;
  localparam logic [FUNC_W-1:0] FUNC_SRL = 6'b000010;
  localparam logic [FUNC_W-1:0] FUNC_SRA = 6'b000011;
  localparam logic [FUNC_W-1:0] FUNC_ADD = 6'b100000;
  localparam logic [FUNC_W-1:0] FUNC_SUB = 6'b100010;
  localparam logic [FUNC_W-1:0] FUNC_AND = 6'b100100;
  localparam logic [FUNC_W-1:0] FUNC_OR  = 6'b100101;
  localparam logic [FUNC_W-1:0] FUNC_XOR = 6'b100110;
  localparam logic [FUNC_W-1:0] FUNC_SLT = 6'b101010;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] pc;
  } entry_t;

  // Register zero is hardwired, so a writeback to it never forwards.
  function automatic logic fwd_hit(input logic en,
                                   input logic [REG_W-1:0] fwd_rd,
                                   input logic [REG_W-1:0] src);
    return en && (fwd_rd != '0) && (fwd_rd == src);
  endfunction

  function automatic logic [1:0] occ_count(input occ_e st);
    logic [1:0] cnt;
    cnt = 2'd0;
    case (st)
      ST_ONE:  cnt = 2'd1;
      ST_TWO:  cnt = 2'd2;
      default: cnt = 2'd0;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/ex_fwd_mux.sv
// Writeback forwarding for one op record: replaces operand A and/or B with
// the writeback value when the matching source register is being written.
module ex_fwd_mux
  import ex_issue_pkg::*;
(
  input  logic              valid,
  input  logic              fwd_en,
  input  logic [REG_W-1:0]  fwd_rd,
  input  logic [DATA_W-1:0] fwd_data,
  input  entry_t            entry_in,
  output entry_t            entry_out
);

  always_comb begin
    entry_out = entry_in;
    if (fwd_hit(valid && fwd_en, fwd_rd, entry_in.rs)) begin
      entry_out.a = fwd_data;
    end
    if (fwd_hit(valid && fwd_en, fwd_rd, entry_in.rt)) begin
      entry_out.b = fwd_data;
    end
  end

endmodule

// File: rtl/ex_issue_stage.sv
// Two-entry skid buffer between decode and the ALU, with writeback
// forwarding applied both to incoming ops and to ops already held.
module ex_issue_stage
  import ex_issue_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [FUNC_W-1:0] in_func,
  input  logic [REG_W-1:0]  in_rs,
  input  logic [REG_W-1:0]  in_rt,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              fwd_en,
  input  logic [REG_W-1:0]  fwd_rd,
  input  logic [DATA_W-1:0] fwd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [FUNC_W-1:0] out_func,
  output logic [REG_W-1:0]  out_rd,
  output logic [DATA_W-1:0] out_pc
);

  occ_e   state;
  entry_t head;
  entry_t skid;
  entry_t in_entry;
  entry_t cap;
  entry_t head_fwd;
  entry_t skid_fwd;
  logic   in_fire;
  logic   out_fire;

  // Handshakes depend on registered occupancy only, never on out_ready.
  assign in_ready  = (int'(occ_count(state)) < DEPTH);
  assign out_valid = (state != ST_EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign in_entry = '{a: in_a, b: in_b, func: in_func, rs: in_rs,
                      rt: in_rt, rd: in_rd, pc: in_pc};

  ex_fwd_mux u_fwd_cap (
    .valid     (in_valid),
    .fwd_en    (fwd_en),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .entry_in  (in_entry),
    .entry_out (cap)
  );

  ex_fwd_mux u_fwd_head (
    .valid     (state != ST_EMPTY),
    .fwd_en    (fwd_en),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .entry_in  (head),
    .entry_out (head_fwd)
  );

  ex_fwd_mux u_fwd_skid (
    .valid     (state == ST_TWO),
    .fwd_en    (fwd_en),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .entry_in  (skid),
    .entry_out (skid_fwd)
  );

  // Held entries always reload from their forwarded view so a stalled op
  // picks up a writeback that lands while it waits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_EMPTY;
      head  <= '0;
      skid  <= '0;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            head  <= cap;
            state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            head <= cap;
          end else if (in_fire) begin
            head  <= head_fwd;
            skid  <= cap;
            state <= ST_TWO;
          end else if (out_fire) begin
            state <= ST_EMPTY;
          end else begin
            head <= head_fwd;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            head  <= skid_fwd;
            state <= ST_ONE;
          end else begin
            head <= head_fwd;
            skid <= skid_fwd;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  assign out_a    = head.a;
  assign out_b    = head.b;
  assign out_func = head.func;
  assign out_rd   = head.rd;
  assign out_pc   = head.pc;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Scoreboard bench for ex_issue_stage: stimulus pushes hand-computed results,
// a negedge monitor pops and compares each op the stage hands to the ALU.
module tb_ex_issue_stage;
  import ex_issue_pkg::*;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [5:0]  in_func;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [31:0] in_pc;
  logic        fwd_en;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [5:0]  out_func;
  logic [4:0]  out_rd;
  logic [31:0] out_pc;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  func;
    logic [4:0]  rd;
    logic [31:0] pc;
  } exp_t;

  exp_t sbQ[$];
  int   checkCount = 0;
  int   passCount  = 0;

  ex_issue_stage #(.DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_func   (in_func),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_pc     (in_pc),
    .fwd_en    (fwd_en),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_func  (out_func),
    .out_rd    (out_rd),
    .out_pc    (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor: every ALU handoff must match the oldest outstanding expectation.
  initial begin
    exp_t got;
    exp_t want;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        got = '{a: out_a, b: out_b, func: out_func, rd: out_rd, pc: out_pc};
        checkCount++;
        if (sbQ.size() == 0) begin
          $display("[TB] FAIL sb_unexpected: got a=%h b=%h func=%b rd=%0d pc=%h, required no op",
                   got.a, got.b, got.func, got.rd, got.pc);
        end else begin
          want = sbQ.pop_front();
          if (got == want) begin
            passCount++;
          end else begin
            $display("[TB] FAIL sb_op: got a=%h b=%h func=%b rd=%0d pc=%h, required a=%h b=%h func=%b rd=%0d pc=%h",
                     got.a, got.b, got.func, got.rd, got.pc,
                     want.a, want.b, want.func, want.rd, want.pc);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  // Offers one op, waits (bounded) for acceptance, and records its result.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [5:0] func, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd,
                               input logic [31:0] pc, input logic [31:0] expA,
                               input logic [31:0] expB);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_a = a; in_b = b; in_func = func;
    in_rs = rs; in_rt = rt; in_rd = rd; in_pc = pc;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checkCount++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for pc=%h, required acceptance", pc);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      sbQ.push_back('{a: expA, b: expB, func: func, rd: rd, pc: pc});
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkCount++;
    if (sbQ.size() == 0) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d ops still pending, required 0", name, sbQ.size());
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_func = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_pc = '0;
    fwd_en = 1'b0; fwd_rd = '0; fwd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_a", out_a, 32'h0);
    checkOutput("rst_out_pc", out_pc, 32'h0);
    checkOutput("rst_out_func_rd", {21'd0, out_func, out_rd}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Passthrough with one-cycle latency, then back to empty.
    out_ready = 1'b1;
    applyStimulus(32'd5, 32'd7, FUNC_SRL, 5'd0, 5'd0, 5'd3, 32'h100, 32'd5, 32'd7);
    checkOutput("pass_latency_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("pass_then_empty", 32'(out_valid), 32'd0);

    // Backpressure: two ops fill the buffer, third waits in decode.
    out_ready = 1'b0;
    applyStimulus(32'h11, 32'h12, FUNC_ADD, 5'd1, 5'd2, 5'd10, 32'h104, 32'h11, 32'h12);
    applyStimulus(32'h21, 32'h22, FUNC_SUB, 5'd1, 5'd2, 5'd11, 32'h108, 32'h21, 32'h22);
    checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
    checkOutput("bp_head_hold", out_a, 32'h11);
    fork
      applyStimulus(32'h31, 32'h32, FUNC_XOR, 5'd1, 5'd2, 5'd12, 32'h10C, 32'h31, 32'h32);
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    waitDrain("bp_drain");

    // Forwarding at capture, then the register-zero guard.
    fwd_en = 1'b1; fwd_rd = 5'd4; fwd_data = 32'hDEAD_BEEF;
    applyStimulus(32'h0000_0011, 32'h22, FUNC_ADD, 5'd4, 5'd6, 5'd7, 32'h200,
                  32'hDEAD_BEEF, 32'h22);
    fwd_rd = 5'd0; fwd_data = 32'h0BAD_0BAD;
    applyStimulus(32'h1234, 32'h5678, FUNC_OR, 5'd0, 5'd0, 5'd8, 32'h204,
                  32'h1234, 32'h5678);
    fwd_en = 1'b0;
    waitDrain("fwdcap_drain");

    // Writeback lands on the stalled head's rt.
    out_ready = 1'b0;
    applyStimulus(32'd1, 32'd7, FUNC_SUB, 5'd2, 5'd9, 5'd5, 32'h300, 32'd1, 32'd100);
    fwd_en = 1'b1; fwd_rd = 5'd9; fwd_data = 32'd100;
    @(posedge clk);
    #1;
    fwd_en = 1'b0;
    checkOutput("stall_fwd_b", out_b, 32'd100);
    checkOutput("stall_fwd_a_kept", out_a, 32'd1);
    out_ready = 1'b1;
    waitDrain("stall_drain");

    // Writeback lands on the skid entry; a write to r0 must not.
    out_ready = 1'b0;
    applyStimulus(32'd10, 32'd20, FUNC_AND, 5'd3, 5'd4, 5'd1, 32'h400, 32'd10, 32'd20);
    applyStimulus(32'd30, 32'd40, FUNC_OR, 5'd12, 5'd0, 5'd2, 32'h404, 32'h55, 32'd40);
    fwd_en = 1'b1; fwd_rd = 5'd12; fwd_data = 32'h55;
    @(posedge clk);
    #1;
    fwd_rd = 5'd0; fwd_data = 32'h77;
    @(posedge clk);
    #1;
    fwd_en = 1'b0;
    out_ready = 1'b1;
    waitDrain("skid_drain");

    // Flush from ONE while an input transfer is also happening.
    out_ready = 1'b0;
    applyStimulus(32'hA1, 32'hA2, FUNC_SLT, 5'd1, 5'd2, 5'd13, 32'h500, 32'hA1, 32'hA2);
    in_valid = 1'b1; in_a = 32'hC3; in_b = 32'hC4; in_rd = 5'd14; in_pc = 32'h504;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    sbQ.delete();
    checkOutput("flush1_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush1_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("flush1_stays_empty", 32'(out_valid), 32'd0);

    // Flush from TWO with an op offered at the same edge.
    out_ready = 1'b0;
    applyStimulus(32'hB1, 32'hB2, FUNC_ADD, 5'd1, 5'd2, 5'd15, 32'h600, 32'hB1, 32'hB2);
    applyStimulus(32'hB3, 32'hB4, FUNC_ADD, 5'd1, 5'd2, 5'd16, 32'h604, 32'hB3, 32'hB4);
    in_valid = 1'b1; in_a = 32'hB5; in_pc = 32'h608;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    sbQ.delete();
    checkOutput("flush2_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush2_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset while full, then one op must appear alone.
    out_ready = 1'b0;
    applyStimulus(32'hE1, 32'hE2, FUNC_SLL, 5'd1, 5'd2, 5'd17, 32'h700, 32'hE1, 32'hE2);
    applyStimulus(32'hE3, 32'hE4, FUNC_SRA, 5'd1, 5'd2, 5'd18, 32'h704, 32'hE3, 32'hE4);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("arst_out_a", out_a, 32'h0);
    sbQ.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(32'h99, 32'h98, FUNC_XOR, 5'd3, 5'd4, 5'd9, 32'h800, 32'h99, 32'h98);
    waitDrain("arst_drain");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("final_idle", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ex_issue_stage.md
EX_ISSUE_STAGE -- requirements
Module: ex_issue_stage

Interface
REQ-001 SHALL use one clock and one reset: clock is asynchronous active-high reset, as fixed; ports named clk and reset.
REQ-002 SHALL have parameter DEPTH, default 2, meaning the number of buffered entries (fixed at 2; other values unsupported).
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1, rising-edge clock.
- reset, in, 1, asynchronous active-high reset.
- flush, in, 1, discard all held and incoming ops.
- in_valid, in, 1, decode offers an op.
- in_ready, out, 1, stage can accept an op.
- in_a, in, 32, operand A.
- in_b, in, 32, operand B.
- in_func, in, 6, ALU function code.
- in_rs, in, 5, source register index for A.
- in_rt, in, 5, source register index for B.
- in_rd, in, 5, destination register index.
- in_pc, in, 32, op PC.
- fwd_en, in, 1, a writeback result is valid this cycle.
- fwd_rd, in, 5, writeback destination index.
- fwd_data, in, 32, writeback value.
- out_valid, out, 1, op presented to the ALU.
- out_ready, in, 1, downstream accepts the op.
- out_a, out, 32, ALU operand A.
- out_b, out, 32, ALU operand B.
- out_func, out, 6, ALU function code.
- out_rd, out, 5, destination register index.
- out_pc, out, 32, op PC.

Function
REQ-004 SHALL hold two entries, head and skid, with occupancy state EMPTY, ONE, or TWO.
REQ-005 SHALL define transfers as follows: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
REQ-006 SHALL drive in_ready as (state != TWO), taken from registered state only, with no combinational path from out_ready.
REQ-007 SHALL drive out_valid as (state != EMPTY), and all out_* signals SHALL come from the head entry only.
REQ-008 SHALL make these transitions:
- EMPTY + input -> ONE.
- ONE + input, no output -> TWO.
- ONE + output, no input -> EMPTY.
- ONE + input + output -> ONE, with head replaced by the new op.
- TWO + output -> ONE, with skid moved to head.
REQ-009 SHALL deliver an accepted op to the output no earlier than the next cycle (latency 1 cycle when EMPTY), and ops SHALL leave in acceptance order.
REQ-010 SHALL apply forwarding at capture: if fwd_en && fwd_rd != 0 && fwd_rd == in_rs, then fwd_data replaces in_a; the same rule applies to in_rt and in_b.
REQ-011 SHALL also apply forwarding to held entries: each valid held entry whose rs/rt matches (fwd_rd != 0) SHALL have its operand overwritten by fwd_data at the edge, including the head while it is stalled.
REQ-012 SHALL not forward when fwd_rd == 0, and the operand SHALL stay unchanged in that case.
REQ-013 SHALL give flush priority over everything: at the edge the state becomes EMPTY, any concurrent input transfer is dropped, and in_ready is 1 in the following cycle.
REQ-014 SHALL pass out_func unmodified, with no decoding of function codes in this block.
REQ-015 SHALL leave out_* data undefined-but-stable (hold last value) while out_valid == 0, and the bench SHALL NOT check it then.

Reset
REQ-016 SHALL on reset assertion, asynchronously, set state to EMPTY, out_valid to 0, in_ready to 1, and clear all entry fields to 0 (so out_a, out_b, out_pc are 32'h0 and out_func, out_rd are 0).
REQ-017 SHALL, when reset asserts mid-transfer, lose all ops, and the first accepted op after release SHALL appear alone.

Structure
REQ-018 SHALL place the state encodings (EMPTY, ONE, TWO) and the 6-bit function-code constants shared with the ALU in a common package/include.
REQ-019 SHALL implement the per-entry forwarding compare/overwrite as one sub-module, ex_fwd_mux, instantiated once at capture and once per held entry.

Verification
REQ-020 Passthrough: one op (a=5, b=7, func=6'b000010, rd=3), out_ready=1 -> out_valid next cycle with out_a=5, out_b=7, then EMPTY.
REQ-021 Backpressure: out_ready=0, three back-to-back ops offered -> in_ready drops after the 2nd op; 3rd is held by decode; releasing out_ready drains all three in order.
REQ-022 Forward at capture: in_rs=4, fwd_en=1, fwd_rd=4, fwd_data=32'hDEAD_BEEF -> out_a=32'hDEAD_BEEF; repeat with fwd_rd=0 -> out_a = original in_a.
REQ-023 Forward into stalled head: head rt=9 stalled (out_ready=0), fwd_rd=9, data=100 -> after the edge out_b=100.
REQ-024 Flush: state TWO plus simultaneous input with flush=1 -> next cycle out_valid=0, in_ready=1, no old op ever emitted.
REQ-025 Reset mid-stream: assert reset while TWO -> out_valid=0 immediately (asynchronously); after release, a new op emerges alone with correct data.
